// File: rtl/stream_pkg.sv
// Shared helpers for the stream_pack / stream_unpack width converters.
package stream_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Counter must also hold RATIO itself (reported lane count of a full word).
  function automatic int cnt_width(input int ratio);
    return clog2(ratio) + 1;
  endfunction

  function automatic logic lane_hit(input int lane, input int cnt);
    return lane == cnt;
  endfunction

  function automatic logic lane_filled(input int lane, input int cnt);
    return lane < cnt;
  endfunction

endpackage

// File: rtl/stream_pack.sv
// Width-up packer: RATIO narrow FWFT-fifo words -> one wide fifo write, lane 0 in LSBs.
// Optional STREAM_PACK_FLUSH_EN adds flush/out_lanes to emit zero-padded partial words.
module stream_pack
  import stream_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int RATIO = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_WIDTH = cnt_width(RATIO)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_empty_n,
  output logic                 in_read,
  input  logic [IN_WIDTH-1:0]  in_dout,
  input  logic                 out_full_n,
  output logic                 out_write,
  output logic [OUT_WIDTH-1:0] out_din
`ifdef STREAM_PACK_FLUSH_EN
  ,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] out_lanes
`endif
);

  logic [CNT_WIDTH-1:0]           r_cnt;
  logic [RATIO-2:0][IN_WIDTH-1:0] r_lane;
  logic                           r_out_valid;
  logic [OUT_WIDTH-1:0]           r_out_din;

  logic                 w_last, w_drain, w_accept, w_read, w_fill, w_complete, w_load;
  logic [OUT_WIDTH-1:0] w_load_word;

  assign w_last     = (r_cnt == CNT_WIDTH'(RATIO - 1));
  assign w_drain    = r_out_valid & out_full_n;
  assign w_accept   = ~w_last | ~r_out_valid | w_drain;
  // Reset gating keeps in_read low while reset is held, even with cnt already cleared.
  assign w_read     = in_empty_n & w_accept & ~reset;
  assign w_fill     = w_read & ~w_last;
  assign w_complete = w_read & w_last;

  assign in_read   = w_read;
  assign out_write = w_drain;
  assign out_din   = r_out_din;

`ifdef STREAM_PACK_FLUSH_EN
  logic                 r_flush_pend;
  logic [CNT_WIDTH-1:0] r_out_lanes;
  logic [CNT_WIDTH-1:0] w_cnt_after;
  logic                 w_fl_req, w_fl_go;
  logic [OUT_WIDTH-1:0] w_fl_word;

  assign w_cnt_after = w_fill ? r_cnt + 1'b1 : (w_complete ? '0 : r_cnt);
  assign w_fl_req    = flush | r_flush_pend;
  assign w_fl_go     = w_fl_req & (w_cnt_after != '0) & (~r_out_valid | w_drain);

  always_comb begin
    w_fl_word = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (lane_filled(i, int'(w_cnt_after)))
        w_fl_word[i*IN_WIDTH +: IN_WIDTH] = (w_fill && lane_hit(i, int'(r_cnt))) ? in_dout : r_lane[i];
    end
  end

  assign w_load      = w_complete | w_fl_go;
  assign w_load_word = w_complete ? {in_dout, r_lane} : w_fl_word;
  assign out_lanes   = r_out_lanes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_pend <= 1'b0;
      r_out_lanes  <= '0;
    end else begin
      r_flush_pend <= w_fl_req & (w_cnt_after != '0) & ~w_fl_go;
      if (w_complete)   r_out_lanes <= CNT_WIDTH'(RATIO);
      else if (w_fl_go) r_out_lanes <= w_cnt_after;
    end
  end
`else
  assign w_load      = w_complete;
  assign w_load_word = {in_dout, r_lane};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_lane      <= '0;
      r_out_valid <= 1'b0;
      r_out_din   <= '0;
    end else begin
      for (int i = 0; i < RATIO - 1; i++) begin
        if (w_fill && lane_hit(i, int'(r_cnt))) r_lane[i] <= in_dout;
      end
      if (w_load)      r_cnt <= '0;
      else if (w_fill) r_cnt <= r_cnt + 1'b1;
      // A new word loaded in the same cycle as a drain keeps the output valid.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_din   <= w_load_word;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_pack.sv
// Bench for stream_pack: directed phases plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_stream_pack;
  localparam int IW = 32;
  localparam int R  = 4;
  localparam int OW = IW * R;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_empty_n, in_read, out_full_n, out_write;
  logic [IW-1:0] in_dout;
  logic [OW-1:0] out_din;
`ifdef STREAM_PACK_FLUSH_EN
  logic          flush;
  logic [CW-1:0] out_lanes;
`endif

  always #5 clk = ~clk;

  stream_pack #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .clk(clk), .reset(reset),
    .in_empty_n(in_empty_n), .in_read(in_read), .in_dout(in_dout),
    .out_full_n(out_full_n), .out_write(out_write), .out_din(out_din)
`ifdef STREAM_PACK_FLUSH_EN
    , .flush(flush), .out_lanes(out_lanes)
`endif
  );

  // Reference model: narrow words waiting for a wide word, plus one pending output word.
  logic [IW-1:0] part[$];
  bit            has_out, pend, seq_mode;
  logic [OW-1:0] exp_word;
  int            exp_lanes;
  logic [IW-1:0] nxt;
  logic [OW-1:0] wr_log[$];
  int            n_cmp, n_err, n_wr, n_rd, n0;

  localparam logic [OW-1:0] W1234 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [OW-1:0] W5678 = 128'h00000008_00000007_00000006_00000005;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack_q();
    logic [OW-1:0] w;
    w = '0;
    foreach (part[i]) w[i*IW +: IW] = part[i];
    return w;
  endfunction

  function automatic logic [OW-1:0] last_wr();
    if (wr_log.size() == 0) return 'x;
    return wr_log[wr_log.size()-1];
  endfunction

  task automatic model_clear();
    part.delete();
    has_out = 0; pend = 0; exp_word = '0; exp_lanes = 0;
  endtask

  // One clock: drive after negedge, check before posedge, advance model at posedge.
  task automatic cycle(input bit e, input bit f, input bit fl);
    bit exp_rd, exp_wr, can_load;
    in_empty_n = e; out_full_n = f; in_dout = nxt;
`ifdef STREAM_PACK_FLUSH_EN
    flush = fl;
`endif
    #1;
    exp_wr = has_out && f;
    exp_rd = e && (part.size() < R - 1 || !has_out || f);
    check("in_read", in_read, exp_rd);
    check("out_write", out_write, exp_wr);
    if (exp_wr) begin
      check("out_din", out_din, exp_word);
`ifdef STREAM_PACK_FLUSH_EN
      check("out_lanes", out_lanes, exp_lanes);
`endif
    end
    if (out_write) begin
      n_wr++;
      wr_log.push_back(out_din);
    end
    @(posedge clk);
    can_load = !has_out || exp_wr;
    if (exp_wr) has_out = 0;
    if (exp_rd) begin
      part.push_back(nxt);
      n_rd++;
      nxt = seq_mode ? nxt + 1 : $urandom;
    end
    if (part.size() == R) begin
      exp_word = pack_q(); exp_lanes = R; part.delete(); has_out = 1; pend = 0;
    end
`ifdef STREAM_PACK_FLUSH_EN
    else if ((fl || pend) && part.size() > 0) begin
      if (can_load) begin
        exp_word = pack_q(); exp_lanes = part.size(); part.delete(); has_out = 1; pend = 0;
      end else pend = 1;
    end else pend = 0;
`else
    if (fl) pend = 0;
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_wr = 0; n_rd = 0;
    reset = 1'b1; in_empty_n = 1'b1; out_full_n = 1'b1; in_dout = '1;
`ifdef STREAM_PACK_FLUSH_EN
    flush = 1'b0;
`endif
    seq_mode = 1; nxt = 1;
    model_clear();
    #2;
    check("rst_in_read", in_read, 0);
    check("rst_out_write", out_write, 0);
    check("rst_out_din", out_din, 0);
`ifdef STREAM_PACK_FLUSH_EN
    check("rst_out_lanes", out_lanes, 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Stream 1..4 back-to-back; write appears one cycle after the 4th read.
    n0 = n_wr;
    for (int i = 0; i < 4; i++) cycle(1, 1, 0);
    check("t2_no_early_write", n_wr, n0);
    cycle(0, 1, 0);
    check("t2_latency", n_wr, n0 + 1);
    check("t2_word", last_wr(), W1234);

    // Bubbles: alternating empty.
    nxt = 1;
    for (int i = 0; i < 8; i++) cycle(i % 2 == 0, 1, 0);
    cycle(0, 1, 0);
    check("t5_bubble_word", last_wr(), W1234);

    // Back-pressure: 8 words offered while downstream full.
    nxt = 1; n0 = n_rd; wr_log.delete();
    for (int i = 0; i < 10; i++) cycle(1, 0, 0);
    check("t3_reads_before_stall", n_rd - n0, 7);
    check("t3_no_write_while_full", wr_log.size(), 0);
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    check("t3_write_count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("t3_first", wr_log[0], W1234);
      check("t3_second", wr_log[1], W5678);
    end

    // Throughput: 64 continuous words.
    nxt = 1; n0 = n_rd; wr_log.delete();
    for (int i = 0; i < 64; i++) cycle(1, 1, 0);
    check("t4_reads", n_rd - n0, 64);
    cycle(0, 1, 0);
    check("t4_writes", wr_log.size(), 16);

    // Reset mid-stream with two lanes filled.
    nxt = 1;
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    in_empty_n = 1'b1; out_full_n = 1'b1; reset = 1'b1;
    #1;
    check("t1_in_read", in_read, 0);
    check("t1_out_write", out_write, 0);
    check("t1_out_din", out_din, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    nxt = 1; wr_log.delete();
    for (int i = 0; i < 4; i++) cycle(1, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    check("t1_one_word", wr_log.size(), 1);
    check("t1_word", last_wr(), W1234);

    // Random traffic.
    seq_mode = 0; nxt = $urandom;
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0);

`ifdef STREAM_PACK_FLUSH_EN
    // Partial flush of 0xA, 0xB.
    do_reset();
    seq_mode = 1; nxt = 32'hA; wr_log.delete();
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    cycle(0, 1, 1);
    cycle(0, 1, 0);
    check("t6_flush_word", last_wr(), 128'h0000000B_0000000A);
    check("t6_flush_count", wr_log.size(), 1);
    // Flush held pending behind a stuck full word.
    nxt = 1; wr_log.delete();
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);
    cycle(0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    check("t6_pending_no_write", wr_log.size(), 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    check("t6_pending_count", wr_log.size(), 2);
    check("t6_pending_word", last_wr(), 128'h00000006_00000005);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
